mem_burst_arbiter: RTL and testbench

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

---
 rtl/mem_burst_arbiter_if.sv | 33 +++
 rtl/mem_burst_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_burst_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_arbiter_if.sv
// Channel request and memory burst signals of the line-fill arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_burst_arbiter_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_LEN = 4
);
  localparam int unsigned LINE_W = BURST_LEN * DATA_W;

  logic [NUM_CH-1:0]        req_read;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]        req_rdata;
  logic [NUM_CH-1:0]        req_resp;
  logic [ADDR_W-1:0]        mem_address;
  logic                     mem_read;
  logic                     mem_write;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_resp;

  modport master (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter serving whole-line read/write bursts from NUM_CH cache
// channels onto a single beat-wide memory port, one burst at a time.
module mem_burst_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  mem_burst_arbiter_if.master bus
);
  localparam int unsigned LINE_W = BURST_LEN * DATA_W;
  localparam int unsigned OFF    = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned PTR_W  = $clog2(NUM_CH);
  localparam int unsigned SUM_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] resp_q, resp_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              found;
  logic [PTR_W-1:0]  pick;
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W-1:0] req_a;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      rdata_q  <= '0;
      resp_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    found    = 1'b0;
    pick     = '0;
    sum      = '0;
    req_a    = '0;

    // First requester at or after rr_ptr, wrapping modulo NUM_CH
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_CH)) sum = sum - SUM_W'(NUM_CH);
      if (!found && (bus.req_read[sum[PTR_W-1:0]] || bus.req_write[sum[PTR_W-1:0]])) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          req_a   = bus.req_addr[pick*ADDR_W +: ADDR_W];
          grant_d = pick;
          addr_d  = (req_a >> OFF) << OFF;
          line_d  = bus.req_wdata[pick*LINE_W +: LINE_W];
          cnt_d   = '0;
          state_d = bus.req_write[pick] ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (bus.mem_resp) begin
          if (state_q == READ) rdata_d[cnt_q*DATA_W +: DATA_W] = bus.mem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_q == PTR_W'(NUM_CH - 1)) ? '0 : grant_q + PTR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == READ);
    wr_d   = (state_d == WRITE);
    resp_d = '0;
    if (state_d == DONE) resp_d[grant_d] = 1'b1;
    wdata_d = wr_d ? line_d[cnt_d*DATA_W +: DATA_W] : '0;
  end

  assign bus.req_rdata   = rdata_q;
  assign bus.req_resp    = resp_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Bench for mem_burst_arbiter: the bench plays both the requesting channels and
// the memory, predicting grants and burst contents from a transaction-level model.
module tb_mem_burst_arbiter;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned LINE_W    = BURST_LEN * DATA_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~32'h1F;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ptr    = 0;

  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .BURST_LEN(BURST_LEN)) bus ();

  mem_burst_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .BURST_LEN(BURST_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    bus.req_read[c]  = rd;
    bus.req_write[c] = wr;
    bus.req_addr[c*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[c*LINE_W +: LINE_W] = d;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Round-robin model: first requesting channel starting from ptr
  function automatic int model_pick();
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (ptr + i) % NUM_CH;
      if (bus.req_read[c] || bus.req_write[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_read"},    bus.mem_read,    '0);
    chk({tag, "_mem_write"},   bus.mem_write,   '0);
    chk({tag, "_req_resp"},    bus.req_resp,    '0);
    chk({tag, "_req_rdata"},   bus.req_rdata,   '0);
    chk({tag, "_mem_address"}, bus.mem_address, '0);
    chk({tag, "_mem_wdata"},   bus.mem_wdata,   '0);
  endtask

  // Act as memory for one whole burst; called at an IDLE-cycle negedge.
  task automatic serve(input int gap_max, input bit fixed, input bit keep);
    int                ch;
    int                n;
    int                gap;
    bit                wr;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] wl;
    logic [LINE_W-1:0] rl;
    logic [DATA_W-1:0] b;
    ch = model_pick();
    if (ch < 0) begin
      $display("FAIL serve_setup observed=no_request expected=request");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench setup");
    end
    wr = bus.req_write[ch];
    ea = bus.req_addr[ch*ADDR_W +: ADDR_W] & LINE_MASK;
    wl = bus.req_wdata[ch*LINE_W +: LINE_W];
    rl = '0;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_read || bus.mem_write) && n < 8);
    chk("cmd_latency", LINE_W'(n), LINE_W'(1));
    if (!(bus.mem_read || bus.mem_write)) return;
    // Requester may change its inputs once granted
    bus.req_addr[ch*ADDR_W +: ADDR_W]  = $urandom;
    bus.req_wdata[ch*LINE_W +: LINE_W] = rand_line();
    for (int k = 0; k < BURST_LEN; k++) begin
      gap = $urandom_range(0, gap_max);
      for (int g = 0; g <= gap; g++) begin
        if (g > 0) @(negedge clk);
        chk("mem_read",    bus.mem_read,    !wr);
        chk("mem_write",   bus.mem_write,   wr);
        chk("mem_address", bus.mem_address, ea);
        if (wr) chk("mem_wdata", bus.mem_wdata, wl[k*DATA_W +: DATA_W]);
        chk("req_resp_busy", bus.req_resp, '0);
      end
      b = fixed ? {16{4'(k + 1)}} : {$urandom, $urandom};
      rl[k*DATA_W +: DATA_W] = b;
      bus.mem_rdata = b;
      bus.mem_resp  = 1'b1;
      @(negedge clk);
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
    end
    chk("req_resp", bus.req_resp, LINE_W'(1) << ch);
    if (!wr) chk("req_rdata", bus.req_rdata, rl);
    chk("cmd_off", {bus.mem_read, bus.mem_write}, '0);
    if (!keep) begin
      bus.req_read[ch]  = 1'b0;
      bus.req_write[ch] = 1'b0;
    end
    ptr = (ch + 1) % NUM_CH;
    @(negedge clk);
    chk("req_resp_pulse", bus.req_resp, '0);
  endtask

  initial begin
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    ptr = 0;
    @(negedge clk);

    // Channel 0 line read with known beats
    set_req(0, 1'b1, 1'b0, 32'h0000_1234, '0);
    serve(0, 1'b1, 1'b0);

    // Channel 1 line write
    set_req(1, 1'b0, 1'b1, 32'h0000_8000, rand_line());
    serve(1, 1'b0, 1'b0);

    // mem_resp while idle has no effect
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    chk("idle_resp_mem_read", bus.mem_read, '0);
    chk("idle_resp_req_resp", bus.req_resp, '0);
    @(negedge clk);

    // Pointer sits at 2: channel 3 wins over channel 1, then channel 1
    set_req(1, 1'b1, 1'b0, $urandom, rand_line());
    set_req(3, 1'b1, 1'b1, $urandom, rand_line());
    serve(2, 1'b0, 1'b0);
    serve(2, 1'b0, 1'b0);

    // Fresh reset, both channels held: grants alternate
    rst = 1'b0;
    ptr = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, $urandom, rand_line());
    set_req(1, 1'b0, 1'b1, $urandom, rand_line());
    for (int i = 0; i < 4; i++) serve(3, 1'b0, i != 3);
    bus.req_read  = '0;
    bus.req_write = '0;
    @(negedge clk);

    // Reset in the middle of a channel 0 read
    set_req(0, 1'b1, 1'b0, $urandom, '0);
    @(negedge clk);
    chk("midrst_cmd", bus.mem_read, 1'b1);
    for (int k = 0; k < 2; k++) begin
      bus.mem_rdata = {$urandom | 32'h1, $urandom};
      bus.mem_resp  = 1'b1;
      @(negedge clk);
      bus.mem_resp  = 1'b0;
    end
    rst = 1'b0;
    ptr = 0;
    #1;
    chk_reset_outputs("midrst");
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, $urandom, '0);
    @(negedge clk);
    chk("midrst_no_resp", bus.req_resp, '0);
    rst = 1'b1;
    serve(1, 1'b0, 1'b0);

    // Random traffic across all channels
    for (int t = 0; t < 24; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!(bus.req_read[c] || bus.req_write[c]) && $urandom_range(0, 1) == 1) begin
          int op;
          op = $urandom_range(0, 2);
          set_req(c, op != 1, op != 0, $urandom, rand_line());
        end
      end
      if (bus.req_read == '0 && bus.req_write == '0)
        set_req($urandom_range(0, NUM_CH - 1), 1'b1, 1'b0, $urandom, rand_line());
      serve(3, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
